// File: rtl/vec_player_pkg.sv
// rtl/vec_player_pkg.sv - shared types, FIFO entry layout and helpers for vec_player
package vec_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RPT_W = 8;

    // Entry layout, msb to lsb: {eot, eop, rpt[7:0], mask, expect, drive}
    function automatic int expect_lsb(input int nin);
        return nin;
    endfunction

    function automatic int mask_lsb(input int nin, input int nout);
        return nin + nout;
    endfunction

    function automatic int rpt_lsb(input int nin, input int nout);
        return nin + 2 * nout;
    endfunction

    function automatic int eop_bit(input int nin, input int nout);
        return rpt_lsb(nin, nout) + RPT_W;
    endfunction

    function automatic int eot_bit(input int nin, input int nout);
        return rpt_lsb(nin, nout) + RPT_W + 1;
    endfunction

    function automatic int entry_w(input int nin, input int nout);
        return eot_bit(nin, nout) + 1;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vec_player_fifo.sv
// rtl/vec_player_fifo.sv - single-clock vector FIFO with full/empty and registered occupancy
module vec_player_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_player.sv
// rtl/vec_player.sv - on-chip vector replay engine; VEC_PLAYER_DIAG_EN adds first-miscompare capture
module vec_player
    import vec_player_pkg::*;
#(
    parameter int NIN   = 20,
    parameter int NOUT  = 22,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            vec_valid,
    output logic            vec_ready,
    input  logic [NIN-1:0]  vec_drive,
    input  logic [NOUT-1:0] vec_expect,
    input  logic [NOUT-1:0] vec_mask,
    input  logic [7:0]      vec_rpt,
    input  logic            vec_eop,
    input  logic            vec_eot,
    output logic [NIN-1:0]  dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [CNTW-1:0] pattern_number,
    output logic [CNTW-1:0] vector_number,
    output logic [CNTW-1:0] miscompare_count,
    output logic            stall
`ifdef VEC_PLAYER_DIAG_EN
    ,
    output logic            err_valid,
    output logic [CNTW-1:0] err_vector,
    output logic [CNTW-1:0] err_pattern,
    output logic [NOUT-1:0] err_bits
`endif
);

    localparam int EW      = entry_w(NIN, NOUT);
    localparam int EXP_LSB = expect_lsb(NIN);
    localparam int MSK_LSB = mask_lsb(NIN, NOUT);
    localparam int RPT_LSB = rpt_lsb(NIN, NOUT);
    localparam int EOP_BIT = eop_bit(NIN, NOUT);
    localparam int EOT_BIT = eot_bit(NIN, NOUT);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t          state;
    state_t          next_state;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      rd_rpt;

    // Apply stage: the vector currently on dut_in and how many cycles it still owns
    logic            app_valid;
    logic [7:0]      app_left;
    logic [NOUT-1:0] app_expect;
    logic [NOUT-1:0] app_mask;
    logic            app_eop;
    logic            app_eot;
    logic            fin;

    logic            launch;
    logic            run_step;
    logic            scoring;
    logic            app_last;
    logic            hold_vec;
    logic            pop;
    logic [NOUT-1:0] mis_bits;
    logic            mis;

    assign wr_entry = {vec_eot, vec_eop, vec_rpt, vec_mask, vec_expect, vec_drive};
    assign rd_rpt   = rd_entry[RPT_LSB +: 8];

    vec_player_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vec_valid && vec_ready),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign vec_ready = !fifo_full;
    assign stall     = busy && fifo_empty;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (abort || fin) next_state = DONE;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // fin marks the extra RUN cycle after the final eot compare; nothing is popped or scored in it
    assign launch   = (state != RUN) && start;
    assign run_step = (state == RUN) && !abort && !fin;
    assign scoring  = run_step && app_valid;
    assign app_last = (app_left == 8'd1);
    assign hold_vec = app_valid && !app_last;
    assign pop      = run_step && !hold_vec && !(app_valid && app_eot) && !fifo_empty;
    assign mis_bits = (dut_out ^ app_expect) & app_mask;
    assign mis      = scoring && (|mis_bits);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            fail             <= 1'b0;
            dut_in           <= '0;
            pattern_number   <= '0;
            vector_number    <= '0;
            miscompare_count <= '0;
            app_valid        <= 1'b0;
            app_left         <= 8'd0;
            app_expect       <= '0;
            app_mask         <= '0;
            app_eop          <= 1'b0;
            app_eot          <= 1'b0;
            fin              <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
            if (launch) begin
                fail             <= 1'b0;
                pattern_number   <= '0;
                vector_number    <= '0;
                miscompare_count <= '0;
                app_valid        <= 1'b0;
                fin              <= 1'b0;
            end else if ((state == RUN) && (abort || fin)) begin
                app_valid <= 1'b0;
                fin       <= 1'b0;
            end else if (run_step) begin
                if (scoring) begin
                    vector_number <= vector_number + CNT_ONE;
                    if (app_last && app_eop) begin
                        pattern_number <= pattern_number + CNT_ONE;
                    end
                    if (app_last && app_eot) begin
                        fin <= 1'b1;
                    end
                    if (mis) begin
                        miscompare_count <= CNTW'(sat_inc(32'(miscompare_count), CNTW));
                        fail             <= 1'b1;
                    end
                end
                if (hold_vec) begin
                    app_left <= app_left - 8'd1;
                end else if (pop) begin
                    app_valid  <= 1'b1;
                    app_left   <= (rd_rpt == 8'd0) ? 8'd1 : rd_rpt;
                    app_expect <= rd_entry[EXP_LSB +: NOUT];
                    app_mask   <= rd_entry[MSK_LSB +: NOUT];
                    app_eop    <= rd_entry[EOP_BIT];
                    app_eot    <= rd_entry[EOT_BIT];
                    dut_in     <= rd_entry[NIN-1:0];
                end else begin
                    app_valid <= 1'b0;
                end
            end
        end
    end

`ifdef VEC_PLAYER_DIAG_EN
    // Counters are captured before this cycle's update: the failing cycle's own index
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err_valid   <= 1'b0;
            err_vector  <= '0;
            err_pattern <= '0;
            err_bits    <= '0;
        end else if (mis && !err_valid) begin
            err_valid   <= 1'b1;
            err_vector  <= vector_number;
            err_pattern <= pattern_number;
            err_bits    <= mis_bits;
        end
    end
`endif

endmodule

// File: tb/tb_vec_player.sv
// tb/tb_vec_player.sv - randomized self-checking bench for vec_player against a queue-based model
module tb_vec_player;

    localparam int NIN   = 4;
    localparam int NOUT  = 4;
    localparam int DEPTH = 8;
    localparam int CNTW  = 4;
    localparam int CMAX  = 15;
    localparam int CMOD  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            vec_valid = 1'b0;
    logic            vec_ready;
    logic [NIN-1:0]  vec_drive = '0;
    logic [NOUT-1:0] vec_expect = '0;
    logic [NOUT-1:0] vec_mask = '0;
    logic [7:0]      vec_rpt = '0;
    logic            vec_eop = 1'b0;
    logic            vec_eot = 1'b0;
    logic [NIN-1:0]  dut_in;
    logic [NOUT-1:0] dut_out = '0;
    logic            busy;
    logic            done;
    logic            fail;
    logic [CNTW-1:0] pattern_number;
    logic [CNTW-1:0] vector_number;
    logic [CNTW-1:0] miscompare_count;
    logic            stall;
`ifdef VEC_PLAYER_DIAG_EN
    logic            err_valid;
    logic [CNTW-1:0] err_vector;
    logic [CNTW-1:0] err_pattern;
    logic [NOUT-1:0] err_bits;
`endif

    always #5 clk = ~clk;

    vec_player #(
        .NIN   (NIN),
        .NOUT  (NOUT),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .vec_valid        (vec_valid),
        .vec_ready        (vec_ready),
        .vec_drive        (vec_drive),
        .vec_expect       (vec_expect),
        .vec_mask         (vec_mask),
        .vec_rpt          (vec_rpt),
        .vec_eop          (vec_eop),
        .vec_eot          (vec_eot),
        .dut_in           (dut_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .fail             (fail),
        .pattern_number   (pattern_number),
        .vector_number    (vector_number),
        .miscompare_count (miscompare_count),
        .stall            (stall)
`ifdef VEC_PLAYER_DIAG_EN
        ,
        .err_valid        (err_valid),
        .err_vector       (err_vector),
        .err_pattern      (err_pattern),
        .err_bits         (err_bits)
`endif
    );

    typedef struct {
        int drive;
        int exp_v;
        int mask;
        int rpt;
        bit eop;
        bit eot;
    } vec_t;

    // Model: a queue of stored vectors, the vector in play with its remaining repeats, and results
    vec_t q[$];
    vec_t cur;
    bit   cur_on;
    int   left;
    int   m_state;      // 0 idle, 1 running, 2 finished
    bit   m_finishing;
    int   m_dut_in, m_pn, m_vn, m_mc;
    bit   m_fail;
    bit   m_ev;
    int   m_evec, m_epat, m_ebits;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    bit   auto_dut = 1'b1;
    logic [NOUT-1:0] flip = '0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_results();
        m_pn = 0; m_vn = 0; m_mc = 0; m_fail = 0;
        m_ev = 0; m_evec = 0; m_epat = 0; m_ebits = 0;
    endtask

    task automatic model_step();
        int   n0;
        bit   push;
        vec_t nv;
        int   bits;
        n0       = q.size();
        push     = vec_valid && (n0 < DEPTH);
        nv.drive = int'(vec_drive);
        nv.exp_v = int'(vec_expect);
        nv.mask  = int'(vec_mask);
        nv.rpt   = int'(vec_rpt);
        nv.eop   = vec_eop;
        nv.eot   = vec_eot;
        if (rst) begin
            q.delete();
            m_state = 0; m_finishing = 0; cur_on = 0; left = 0; m_dut_in = 0;
            clear_results();
        end else begin
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1; cur_on = 0; m_finishing = 0;
                    clear_results();
                end
            end else if (abort || m_finishing) begin
                m_state = 2; cur_on = 0; m_finishing = 0;
            end else begin
                if (cur_on) begin
                    bits = (int'(dut_out) ^ cur.exp_v) & cur.mask;
                    if (bits != 0) begin
                        if (!m_ev) begin
                            m_ev = 1; m_evec = m_vn; m_epat = m_pn; m_ebits = bits;
                        end
                        if (m_mc < CMAX) m_mc++;
                        m_fail = 1;
                    end
                    m_vn = (m_vn + 1) % CMOD;
                    if (left == 1) begin
                        if (cur.eop) m_pn = (m_pn + 1) % CMOD;
                        if (cur.eot) m_finishing = 1;
                    end
                end
                if (cur_on && left > 1) begin
                    left--;
                end else if (!m_finishing && q.size() > 0) begin
                    cur      = q.pop_front();
                    left     = (cur.rpt == 0) ? 1 : cur.rpt;
                    cur_on   = 1;
                    m_dut_in = cur.drive;
                end else begin
                    cur_on = 0;
                end
            end
            if (push) q.push_back(nv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut_in", int'(dut_in), m_dut_in);
            chk("busy", int'(busy), int'(m_state == 1));
            chk("done", int'(done), int'(m_state == 2));
            chk("fail", int'(fail), int'(m_fail));
            chk("pattern_number", int'(pattern_number), m_pn);
            chk("vector_number", int'(vector_number), m_vn);
            chk("miscompare_count", int'(miscompare_count), m_mc);
            chk("stall", int'(stall), int'(m_state == 1 && q.size() == 0));
            chk("vec_ready", int'(vec_ready), int'(q.size() < DEPTH));
`ifdef VEC_PLAYER_DIAG_EN
            chk("err_valid", int'(err_valid), int'(m_ev));
            chk("err_vector", int'(err_vector), m_evec);
            chk("err_pattern", int'(err_pattern), m_epat);
            chk("err_bits", int'(err_bits), m_ebits);
`endif
        end
    end

    // dut_out echoes the model's applied expect, optionally corrupted by flip
    task automatic tick();
        if (auto_dut) dut_out = (cur_on ? NOUT'(cur.exp_v) : '0) ^ flip;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic push_vec(input int d, input int e, input int m, input int r,
                            input bit eop, input bit eot);
        vec_valid  = 1'b1;
        vec_drive  = NIN'(d);
        vec_expect = NOUT'(e);
        vec_mask   = NOUT'(m);
        vec_rpt    = 8'(r);
        vec_eop    = eop;
        vec_eot    = eot;
        tick();
        vec_valid  = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && !done; i++) tick();
        chk(name, int'(done), 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_dut_in", int'(dut_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_vec_ready", int'(vec_ready), 1);
        chk("rst_vector_number", int'(vector_number), 0);

        // Three matching vectors, last closes pattern and test
        push_vec(1, 3, 'hF, 1, 0, 0);
        push_vec(2, 5, 'hF, 0, 0, 0);
        push_vec(4, 6, 'hF, 1, 1, 1);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        chk("t1_done_early", int'(done), 0);
        tick();
        chk("t1_done", int'(done), 1);
        chk("t1_vn", int'(vector_number), 3);
        chk("t1_pn", int'(pattern_number), 1);
        chk("t1_mc", int'(miscompare_count), 0);
        chk("t1_fail", int'(fail), 0);
        chk("t1_dut_in", int'(dut_in), 4);

        // Repeat 5, the last repeat mismatches (A vs 2)
        push_vec(3, 'hA, 'hF, 5, 1, 1);
        do_start();
        tick();
        for (int i = 0; i < 4; i++) tick();
        flip = 4'h8;
        tick();
        flip = 4'h0;
        tick();
        tick();
        chk("t2_done", int'(done), 1);
        chk("t2_vn", int'(vector_number), 5);
        chk("t2_mc", int'(miscompare_count), 1);
        chk("t2_fail", int'(fail), 1);

        // Fully masked vector never miscompares
        push_vec(7, 5, 0, 1, 0, 1);
        flip = 4'hF;
        do_start();
        run_until_done(10, "t3_wait_done");
        flip = 4'h0;
        chk("t3_mc", int'(miscompare_count), 0);
        chk("t3_fail", int'(fail), 0);
        chk("t3_vn", int'(vector_number), 1);

        // Start on an empty FIFO, vector arrives three cycles later
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_start();
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall", int'(stall), 1);
            chk("t4_dut_in_held", int'(dut_in), 0);
            chk("t4_vn_held", int'(vector_number), 0);
            if (i < 2) tick();
        end
        push_vec(9, 1, 'hF, 2, 1, 1);
        chk("t4_stall_clear", int'(stall), 0);
        tick();
        chk("t4_dut_in", int'(dut_in), 9);
        run_until_done(10, "t4_wait_done");
        chk("t4_vn", int'(vector_number), 2);

        // 20 mismatching cycles saturate a 4-bit miscompare counter; vector_number wraps
        push_vec(5, 'hC, 'hF, 20, 0, 1);
        flip = 4'hF;
        do_start();
        run_until_done(40, "t5_wait_done");
        flip = 4'h0;
        chk("t5_mc", int'(miscompare_count), 15);
        chk("t5_vn", int'(vector_number), 4);
        chk("t5_fail", int'(fail), 1);

        // Abort mid-repeat, then reset
        push_vec(1, 2, 'hF, 10, 0, 1);
        do_start();
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_done", int'(done), 1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_vn", int'(vector_number), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_vn", int'(vector_number), 0);
        chk("t6_rst_dut_in", int'(dut_in), 0);
        chk("t6_rst_fail", int'(fail), 0);

        // Randomized traffic; the compare process checks every cycle against the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 999) == 0);
            start      = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 149) == 0);
            vec_valid  = ($urandom_range(0, 2) != 0);
            vec_drive  = NIN'($urandom);
            vec_expect = NOUT'($urandom);
            vec_mask   = NOUT'($urandom);
            vec_rpt    = 8'($urandom_range(0, 3));
            vec_eop    = ($urandom_range(0, 2) == 0);
            vec_eot    = ($urandom_range(0, 7) == 0);
            flip       = ($urandom_range(0, 5) == 0) ? NOUT'($urandom) : '0;
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
